sseg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed hex seven-segment driver for N common-anode digits.
- Scans one digit per slot with anti-ghosting blank time, per-digit decimal points and enables, and optional leading-zero suppression.
- Double-buffers the displayed value so updates take effect only at frame boundaries.
- Sits between datapath/FSM result registers and the board's segment/anode pins.

---
 rtl/sseg_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_driver
//  Purpose  : Time-multiplexed hex seven-segment driver for N common-anode
//             digits. Each digit slot starts with a dark window against
//             ghosting. The digit value is double-buffered, and per-digit
//             enable, decimal point and leading-zero suppression are
//             supported.
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_driver #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              sseg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Reject parameter sets the scan timing cannot honour.
    if ((N_DIGITS < 1) || (N_DIGITS > 8) || (SCAN_DIV < BLANK_CYC + 2))
    begin : g_bad_params
        $error("sseg_scan_driver: illegal N_DIGITS/SCAN_DIV/BLANK_CYC");
    end

    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*N_DIGITS-1:0]   pend_val;
    logic [N_DIGITS-1:0]     pend_dp;
    logic                    pend_valid;
    logic [4*N_DIGITS-1:0]   active_val;
    logic [N_DIGITS-1:0]     active_dp;

    logic [N_DIGITS:0]       upper_zero;
    logic [N_DIGITS-1:0]     digit_dark;
    logic [N_DIGITS-1:0]     an_sel;
    logic [3:0]              cur_nib;
    logic                    cur_dark;

    assign slot_end  = (div_cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Hex nibble to active-low {a,b,c,d,e,f,g}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0110001;
            4'hD:    decode = 7'b1000010;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    // Slot timer and digit index; the index advances on the last slot cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Double buffer: loads park in pending and are promoted only at the frame
    // boundary; a load on the boundary cycle itself bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            active_val <= '0;
            active_dp  <= '0;
        end else if (frame_end) begin
            if (load) begin
                active_val <= value;
                active_dp  <= dp;
            end else if (pend_valid) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp;
            pend_valid <= 1'b1;
        end
    end

    // One-cycle pulse following the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
        end
    end

    // upper_zero[k] is set when active nibbles k..N_DIGITS-1 are all zero.
    assign upper_zero[N_DIGITS] = 1'b1;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        assign upper_zero[k] = upper_zero[k+1] & (active_val[4*k +: 4] == 4'h0);
        if (k == 0) begin : g_lsd
            // The rightmost digit always shows, even when it is zero.
            assign digit_dark[k] = ~digit_en[k];
        end else begin : g_upper
            assign digit_dark[k] = ~digit_en[k] | (lz_blank & upper_zero[k]);
        end
    end

    // Active-low one-hot anode pattern and the data for the current slot.
    always_comb begin
        an_sel = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                an_sel[k] = 1'b0;
            end
        end
        cur_nib  = active_val[{idx, 2'b00} +: 4];
        cur_dark = digit_dark[idx];
    end

    // Registered pin drive: dark during the blank window or for a dark digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            sseg <= 7'b1111111;
            dp_n <= 1'b1;
        end else if ((div_cnt < CNT_BLANK) || cur_dark) begin
            an   <= '1;
            sseg <= 7'b1111111;
            dp_n <= 1'b1;
        end else begin
            an   <= an_sel;
            sseg <= decode(cur_nib);
            dp_n <= ~active_dp[idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_driver
//  Purpose  : Directed self-checking bench for sseg_scan_driver with
//             N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2. Expected per-slot pin
//             values are queued when a frame's content is known and popped
//             as each slot is observed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    localparam logic [11:0] DARK = 12'hFFF;   // {an, sseg, dp_n} all off

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic [6:0]  sseg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [11:0] sb[$];
    logic [6:0]  dec_tab[16];

    sseg_scan_driver #(
        .N_DIGITS  (N),
        .SCAN_DIV  (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .load       (load),
        .sseg       (sseg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected {an, sseg, dp_n} while digit k is lit, straight from the
    // blanking rules and the decode table.
    function automatic logic [11:0] exp_digit(input int k, input logic [15:0] v,
                                              input logic [3:0] d, input logic [3:0] en,
                                              input logic lz);
        logic [3:0] nib;
        logic [3:0] an_e;
        nib = v[4*k +: 4];
        if (!en[k] || (lz && (k > 0) && ((v >> (4*k)) == 16'h0)))
            return DARK;
        an_e    = 4'hF;
        an_e[k] = 1'b0;
        return {an_e, dec_tab[nib], ~d[k]};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] en, input logic lz);
        for (int k = 0; k < N; k++) sb.push_back(exp_digit(k, v, d, en, lz));
    endtask

    // One clock; outputs are then read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) tick();
    endtask

    // Slot k of frame f: frame_tick shape at frame start, dark during the
    // blank window, expected digit on the first and last lit cycles.
    task automatic check_slot(input int f, input int k);
        logic [11:0] e;
        int          base;
        base = FRAME * f + DIV * k;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty f%0d d%0d observed=0 expected=1", f, k);
            e = DARK;
        end else begin
            e = sb.pop_front();
        end
        if (k == 0) begin
            goto_cyc(base);
            chk($sformatf("frame_tick_hi f%0d", f), frame_tick, (f > 0));
            goto_cyc(base + 1);
            chk($sformatf("frame_tick_lo f%0d", f), frame_tick, 1'b0);
        end
        goto_cyc(base + BLK);
        chk($sformatf("blank f%0d d%0d", f, k), {an, sseg, dp_n}, DARK);
        goto_cyc(base + BLK + 1);
        chk($sformatf("first_lit f%0d d%0d", f, k), {an, sseg, dp_n}, e);
        goto_cyc(base + DIV - 1);
        chk($sformatf("last_lit f%0d d%0d", f, k), {an, sseg, dp_n}, e);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst_n    = 1'b0;
        value    = 16'h0;
        dp       = 4'h0;
        digit_en = 4'h0;
        lz_blank = 1'b0;
        load     = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", {an, sseg, dp_n}, DARK);
        chk("reset_frame_tick", frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Frame 0: load 1234 in cycle 3. The active buffer is still zero, so
        // the enables stay off until the new value is on display.
        value = 16'h1234;
        dp    = 4'h0;
        for (int c = 1; c < FRAME; c++) begin
            goto_cyc(c);
            load = (c == 3);
            chk("pre_first_frame", {an, sseg}, 11'h7FF);
        end
        goto_cyc(FRAME);
        digit_en = 4'hF;

        // Frame 1: basic scan of 1234.
        push_frame(16'h1234, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < N; k++) check_slot(1, k);

        // Frame 2: ABCD loaded during digit 1's slot must not show yet.
        push_frame(16'h1234, 4'h0, 4'hF, 1'b0);
        check_slot(2, 0);
        check_slot(2, 1);
        pulse_load(16'hABCD, 4'h0);
        check_slot(2, 2);
        check_slot(2, 3);

        // Frame 3: ABCD. Park 5555 in pending, then load 9876 on the boundary.
        push_frame(16'hABCD, 4'h0, 4'hF, 1'b0);
        check_slot(3, 0);
        check_slot(3, 1);
        pulse_load(16'h5555, 4'h0);
        check_slot(3, 2);
        check_slot(3, 3);
        pulse_load(16'h9876, 4'b0001);

        // Frames 4 and 5: boundary load wins and the dropped 5555 never shows.
        push_frame(16'h9876, 4'b0001, 4'hF, 1'b0);
        for (int k = 0; k < N; k++) check_slot(4, k);
        push_frame(16'h9876, 4'b0001, 4'hF, 1'b0);
        check_slot(5, 0);
        check_slot(5, 1);
        lz_blank = 1'b1;
        pulse_load(16'h0050, 4'h0);
        check_slot(5, 2);
        check_slot(5, 3);

        // Frame 6: leading zeros of 0050 suppressed; frame 7: 0000.
        push_frame(16'h0050, 4'h0, 4'hF, 1'b1);
        check_slot(6, 0);
        check_slot(6, 1);
        pulse_load(16'h0000, 4'h0);
        check_slot(6, 2);
        check_slot(6, 3);
        push_frame(16'h0000, 4'h0, 4'hF, 1'b1);
        check_slot(7, 0);
        check_slot(7, 1);
        pulse_load(16'h4321, 4'b0100);
        check_slot(7, 2);
        check_slot(7, 3);

        // Frame 8: digit 2 disabled despite its decimal point.
        goto_cyc(8 * FRAME);
        digit_en = 4'b1011;
        lz_blank = 1'b0;
        push_frame(16'h4321, 4'b0100, 4'b1011, 1'b0);
        for (int k = 0; k < N; k++) check_slot(8, k);

        // Frame 9: digit 2 re-enabled with its decimal point lit.
        goto_cyc(9 * FRAME);
        digit_en = 4'hF;
        push_frame(16'h4321, 4'b0100, 4'hF, 1'b0);
        for (int k = 0; k < N; k++) check_slot(9, k);

        // Frame 10: pend FFFF, then reset at idx=2, div_cnt=5.
        push_frame(16'h4321, 4'b0100, 4'hF, 1'b0);
        check_slot(10, 0);
        check_slot(10, 1);
        pulse_load(16'hFFFF, 4'hF);
        goto_cyc(10 * FRAME + 2 * DIV + 5);
        chk("pre_reset_lit", {an, sseg, dp_n}, exp_digit(2, 16'h4321, 4'b0100, 4'hF, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("async_reset_pins", {an, sseg, dp_n}, DARK);
        chk("async_reset_tick", frame_tick, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_pins", {an, sseg, dp_n}, DARK);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // After reset: zero display from digit 0, pending FFFF discarded.
        push_frame(16'h0000, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < N; k++) check_slot(0, k);
        push_frame(16'h0000, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < N; k++) check_slot(1, k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
